spart_tx: RTL and testbench
===========================

Name: spart_tx

Overview:
- UART-style serial transmitter for the SPART block.
- Accepts one parallel byte on a load strobe and shifts it out on TxD as a 10-bit frame: start bit, 8 data bits LSB first, stop bit.
- Bit timing comes from an external 16x oversampling enable tick from the baud generator.
- tbr is the transmit-buffer-ready flag read by the bus interface.

Parameters:
- DATA_BITS, 8, payload width per frame.
- OVERSAMPLE, 16, en ticks per serial bit.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- data  input  DATA_BITS  byte to transmit; sampled only on the cycle en_tx is high.
- en  input  1  baud tick, one-cycle pulse at OVERSAMPLE x bit rate; arbitrary spacing between pulses.
- en_tx  input  1  load strobe, one-cycle pulse requesting transmission of data.
- tbr  output  1  transmit buffer ready; 1 = idle and can accept a byte, 0 = frame in progress.
- TxD  output  1  serial line output; idles high.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, TxD=1, tbr=1, tick counter=0, bit counter=0, shift register cleared. Takes effect immediately, including mid-frame; the partial frame is abandoned.
- States: IDLE, SEND.
- IDLE:
  - TxD=1, tbr=1; en ticks are ignored.
  - On en_tx=1 at a clock edge: latch {1'b1 stop, data, 1'b0 start} into a 10-bit shift register, clear both counters, go to SEND.
  - From that edge onward, TxD=0 (start bit) and tbr=0, i.e. one cycle of latency from en_tx.
- SEND:
  - TxD = shift register bit 0; tbr=0.
  - Each en=1 cycle increments the tick counter (mod OVERSAMPLE).
  - When an en tick arrives with the tick counter at OVERSAMPLE-1: counter wraps to 0, shift register shifts right (fill with 1), bit counter increments.
  - Each bit is therefore held for exactly OVERSAMPLE en ticks, independent of clk cycles between ticks.
  - After the 10th bit (stop) completes its OVERSAMPLE ticks: return to IDLE; tbr=1 and TxD=1 on the same edge.
  - Total frame = 10*OVERSAMPLE en ticks.
- en_tx asserted while in SEND: ignored. No queueing; data is not re-latched.
- en_tx and the final stop-bit tick in the same cycle: frame completes and the new byte is NOT loaded. Software must see tbr=1 before loading.
- en held high continuously: counts one tick per clk cycle.
- data changes after load: no effect on the frame in progress.
- Outputs are registered; no combinational path from inputs to TxD or tbr.

Decomposition:
- Shared package holds:
  - state enum {IDLE, SEND}
  - constants FRAME_BITS=DATA_BITS+2, OVERSAMPLE default, TX_IDLE_LEVEL=1'b1.
- No sub-module required. The tick counter could be split out as spart_tick_div, but it is kept inline (small).

Test Plan:
- Reset: assert rst low mid-operation -> TxD=1 and tbr=1 immediately; after release, idle with no TxD activity despite en pulses.
- Basic frame: data=8'hE3, pulse en_tx, then 16 en pulses per bit spaced 6 clocks apart, sampling TxD before each bit's ticks until tbr rises -> exactly 10 samples, assembled LSB-first = 10'h3C6 (start 0, E3 LSB first, stop 1). tbr low from the cycle after en_tx through 160 ticks.
- Bit timing: count en ticks per TxD level -> each bit held exactly 16 ticks; TxD changes only on clock edges where en=1 and the tick count wraps.
- Busy load: pulse en_tx with data=8'h55 mid-frame of 8'hA5 -> serial output remains 8'hA5; no second frame starts; tbr returns high after one frame.
- Back-to-back: after tbr=1, load 8'h00 then 8'hFF -> frames 10'h200 and 10'h3FE, with TxD high between them.
- Continuous en: en tied high, load 8'h81 -> frame completes in 160 clk cycles; tbr returns to 1 on the edge after the 160th tick.

Source files
------------

// File: rtl/spart_tx_pkg.sv
// spart_tx_pkg: shared types and constants for the SPART transmitter.
//   tx_state_t     - transmitter FSM states
//   DATA_BITS_DEF  - default payload width
//   OVERSAMPLE_DEF - default en ticks per serial bit
//   FRAME_BITS     - start + payload + stop for the default payload width
//   TX_IDLE_LEVEL  - line level while idle (also the stop-bit level)
package spart_tx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  localparam int   DATA_BITS_DEF  = 8;
  localparam int   OVERSAMPLE_DEF = 16;
  localparam int   FRAME_BITS     = DATA_BITS_DEF + 2;
  localparam logic TX_IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/spart_tx.sv
// spart_tx: UART-style serial transmitter.
// Sends one byte per load as start bit, DATA_BITS data bits LSB first and
// a stop bit. Each bit is held for OVERSAMPLE baud ticks (en pulses).
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-low reset
//   data   - byte to send, sampled only when en_tx loads it
//   en     - baud tick, OVERSAMPLE per serial bit
//   en_tx  - load strobe; honoured only while idle
//   tbr    - transmit buffer ready (1 = idle)
//   TxD    - serial output, idles high
module spart_tx
  import spart_tx_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 en,
  input  logic                 en_tx,
  output logic                 tbr,
  output logic                 TxD
);

  localparam int FRAME_LEN = DATA_BITS + 2;
  localparam int TW        = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW        = $clog2(FRAME_LEN);

  localparam logic [TW-1:0] TICK_MAX = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_MAX  = BW'(FRAME_LEN - 1);

  tx_state_t              state, state_nxt;
  logic [TW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [FRAME_LEN-1:0]   shreg;
  logic                   bit_done;
  logic                   frame_done;

  // Current bit has received its last tick; the stop bit finishing ends the frame.
  assign bit_done   = (state == SEND) && en && (tick_cnt == TICK_MAX);
  assign frame_done = bit_done && (bit_cnt == BIT_MAX);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; en_tx during SEND (even on the final tick) is dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en_tx)      state_nxt = SEND;
      SEND:    if (frame_done) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Shift register and tick/bit counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg    <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en_tx) begin
            shreg    <= {TX_IDLE_LEVEL, data, ~TX_IDLE_LEVEL};
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        SEND: begin
          if (en) begin
            if (bit_done) begin
              tick_cnt <= '0;
              shreg    <= {TX_IDLE_LEVEL, shreg[FRAME_LEN-1:1]};
              bit_cnt  <= frame_done ? '0 : bit_cnt + 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only, so no input reaches TxD or tbr
  // combinationally.
  always_comb begin
    tbr = (state == IDLE);
    TxD = (state == SEND) ? shreg[0] : TX_IDLE_LEVEL;
  end

endmodule

// File: tb/tb_spart_tx.sv
// tb_spart_tx: self-checking bench for spart_tx.
// A frame-level model (load -> count ticks -> bit index = ticks / OS)
// predicts tbr and TxD every cycle; directed sequences add literal checks.
module tb_spart_tx;

  localparam int OS = 16;
  localparam int FB = 10;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       en    = 1'b0;
  logic       en_tx = 1'b0;
  logic [7:0] data  = '0;
  logic       tbr;
  logic       TxD;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  spart_tx #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
    .clk   (clk),
    .rst   (rst),
    .data  (data),
    .en    (en),
    .en_tx (en_tx),
    .tbr   (tbr),
    .TxD   (TxD)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Frame-level model
  bit         m_busy  = 1'b0;
  logic [9:0] m_frame = '1;
  int         m_ticks = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy  = 1'b0;
      m_ticks = 0;
    end else if (!m_busy) begin
      if (en_tx) begin
        m_busy  = 1'b1;
        m_frame = {1'b1, data, 1'b0};
        m_ticks = 0;
      end
    end else if (en) begin
      m_ticks++;
      if (m_ticks == OS * FB) m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic exp_txd;
    exp_txd = m_busy ? m_frame[m_ticks / OS] : 1'b1;
    check("tbr_cycle", tbr, !m_busy);
    check("txd_cycle", TxD, exp_txd);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int gap);
    en = 1'b1;
    cyc();
    en = 1'b0;
    repeat (gap - 1) cyc();
  endtask

  task automatic load(input logic [7:0] d);
    data  = d;
    en_tx = 1'b1;
    cyc();
    en_tx = 1'b0;
    data  = 8'($urandom);
  endtask

  // Sample TxD at the start of each bit until tbr rises; optionally pulse
  // en_tx with 8'h55 at the start of bit inject_at.
  task automatic collect(input int inject_at, output logic [9:0] frame, output int nsamp);
    frame = '0;
    nsamp = 0;
    while (!tbr && nsamp < 12) begin
      if (nsamp < FB) frame[nsamp] = TxD;
      if (nsamp == inject_at) begin
        data  = 8'h55;
        en_tx = 1'b1;
        cyc();
        en_tx = 1'b0;
      end
      nsamp++;
      repeat (OS) tick(6);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] fr;
    int         n;

    // Reset state
    repeat (3) cyc();
    check("reset_tbr", tbr, 1'b1);
    check("reset_txd", TxD, 1'b1);
    rst = 1'b1;
    cyc();
    repeat (5) tick(3);
    check("idle_txd", TxD, 1'b1);
    check("idle_tbr", tbr, 1'b1);

    // Basic frame
    load(8'hE3);
    check("load_tbr", tbr, 1'b0);
    check("load_start", TxD, 1'b0);
    collect(-1, fr, n);
    check("e3_samples", n, FB);
    check("e3_frame", fr, 10'h3C6);
    check("e3_tbr_end", tbr, 1'b1);

    // Load attempt while busy
    load(8'hA5);
    collect(3, fr, n);
    check("busy_samples", n, FB);
    check("busy_frame", fr, 10'h34A);
    repeat (20) tick(2);
    check("busy_no_second_tbr", tbr, 1'b1);
    check("busy_no_second_txd", TxD, 1'b1);

    // Back-to-back
    load(8'h00);
    collect(-1, fr, n);
    check("b2b_00_frame", fr, 10'h200);
    repeat (3) cyc();
    check("b2b_gap_txd", TxD, 1'b1);
    load(8'hFF);
    collect(-1, fr, n);
    check("b2b_ff_frame", fr, 10'h3FE);

    // Continuous en
    en = 1'b1;
    load(8'h81);
    fr    = '0;
    fr[0] = TxD;
    n     = 0;
    while (!tbr && n < 300) begin
      cyc();
      n++;
      if (n % OS == 0 && n < OS * FB) fr[n / OS] = TxD;
    end
    en = 1'b0;
    check("cont_cycles", n, OS * FB);
    check("cont_frame", fr, 10'h302);
    cyc();

    // en_tx on the final stop-bit tick is not accepted
    load(8'h3C);
    repeat (OS * FB - 1) tick(2);
    check("final_tick_busy", tbr, 1'b0);
    data  = 8'h00;
    en    = 1'b1;
    en_tx = 1'b1;
    cyc();
    en    = 1'b0;
    en_tx = 1'b0;
    check("final_tick_tbr", tbr, 1'b1);
    check("final_tick_txd", TxD, 1'b1);
    repeat (4) tick(2);
    check("final_tick_still_idle", tbr, 1'b1);

    // Asynchronous reset mid-frame
    load(8'hF0);
    repeat (2 * OS + 4) tick(2);
    check("pre_reset_txd", TxD, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_tbr", tbr, 1'b1);
    check("async_reset_txd", TxD, 1'b1);
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    repeat (20) tick(2);
    check("post_reset_txd", TxD, 1'b1);
    check("post_reset_tbr", tbr, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
